dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the CPU MEM stage and a debug/loader port, so memory can be preloaded and inspected while the pipeline runs. Accesses are serialized and round-robin arbitrated, and the fixed memory latency is sequenced by a counter. While a CPU access is outstanding, the block drives the pipeline stall signal that feeds the hazard/stall logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue to read data valid; legal range 1..15
- CNT_W, 16, performance counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cpu_req_i / cpu_we_i  in  1  CPU access request / write enable
- cpu_addr_i  in  ADDR_W  CPU byte address
- cpu_wdata_i  in  DATA_W  CPU write data
- cpu_rdata_o  out  DATA_W  CPU read data, registered
- cpu_done_o  out  1  one-cycle completion pulse
- cpu_stall_o  out  1  cpu_req_i & ~cpu_done_o, combinational
- dbg_req_i / dbg_we_i  in  1  debug request / write enable
- dbg_addr_i  in  ADDR_W; dbg_wdata_i  in  DATA_W
- dbg_rdata_o  out  DATA_W; dbg_done_o  out  1
- mem_en_o / mem_we_o  out  1  memory enable / write, registered
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W
- mem_rdata_i  in  DATA_W  memory read data
- perf_stall_o, perf_cpu_grant_o, perf_dbg_grant_o  out  CNT_W  (present only with the macro)

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- IDLE, any req sampled high: grant one requester, latch its we/addr/wdata into mem_* outputs, set mem_en_o=1, load lat_cnt=MEM_LAT, go BUSY.
- Arbitration is round-robin on last_q. If both request, grant the one not granted last. After reset last_q=DBG, so the CPU wins the first tie.
- BUSY: mem_en_o is held high only for the first BUSY cycle, then 0. mem_addr/wdata/we stay stable. lat_cnt decrements each edge.
- BUSY with lat_cnt==1 at an edge: on a read, capture mem_rdata_i into the granted requester's rdata; on a write, rdata is unchanged. Pulse that requester's done for one cycle and go IDLE.
- A requester holds req and its operands stable until done. It deasserts req in the done cycle unless it wants another access; a req still high at the next edge is a new request.
- A req dropped mid-access is ignored: the access completes and done still pulses.
- No alignment check; the address passes through unchanged.
- Reset values: state IDLE; mem_en_o, mem_we_o, and both done outputs 0; mem_addr_o, mem_wdata_o, and both rdata outputs 0; last_q DBG; counters 0.
- Reset mid-access abandons the access immediately; no done is issued.

## Timing
- Request sampled at edge E0. mem_en_o is high in cycle E0..E1. done is high in cycle E_MEM_LAT..E_MEM_LAT+1. Latency is MEM_LAT+1 cycles, request to done.
- Next grant is possible at edge E_MEM_LAT+1, so throughput is one access per MEM_LAT+1 cycles.
- With MEM_LAT=1, BUSY lasts one cycle and the issue and capture cycles coincide.
- The losing requester waits exactly one full access before it is granted.

## Configuration
- DMEM_ARB_PERF_EN defined:
  - perf_stall_o counts cycles with cpu_stall_o=1.
  - perf_cpu_grant_o and perf_dbg_grant_o count grants.
  - All three saturate at all-ones and reset to 0.
- DMEM_ARB_PERF_EN undefined: the perf ports and counters are absent.

## Structure
- Shared package dmem_pkg:
  - state enum (IDLE, BUSY)
  - requester enum (CPU=0, DBG=1)
  - MEM_LAT legal-range constants
- One sub-module, rr_arb2: two-input round-robin grant with the last_q register and an update-on-grant input.

## Test plan
- Single CPU read, addr 0x00, memory returns 5, MEM_LAT=2 → cpu_done_o at cycle 3, cpu_rdata_o=5, cpu_stall_o high for cycles 0–2.
- CPU and debug requests in the same cycle after reset → CPU granted first, debug done 3 cycles after the CPU done.
- Back-to-back alternating contention for 10 accesses → grants strictly alternate; perf_cpu_grant_o=5 and perf_dbg_grant_o=5 with the macro.
- Debug write 0x2A to 0x04, then CPU read 0x04 → mem_we_o=1 on the write issue cycle; cpu_rdata_o=0x2A.
- rst_i low during BUSY → mem_en_o=0 and state IDLE immediately; no done pulse; a fresh request after reset completes normally.
- MEM_LAT=1 single read → done 2 cycles after the request.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared types and constants for the data-memory arbiter slice
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Arbiter sequencing states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Requester identities; encoding doubles as the request-vector index
   typedef enum logic [0:0] {
      CPU = 1'b0,
      DBG = 1'b1
   } req_e;

   // Legal memory latency range and the counter width that covers it
   localparam int c_MEM_LAT_MIN = 1;
   localparam int c_MEM_LAT_MAX = 15;
   localparam int c_LAT_W       = 4;

   function automatic bit lat_legal(input int lat);
      return (lat >= c_MEM_LAT_MIN) && (lat <= c_MEM_LAT_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-input round-robin grant; remembers the last winner and
//             favours the other requester on a tie
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,       // asynchronous, active-low
   input  logic [1:0] req_i,       // [0] CPU, [1] DBG
   input  logic       update_i,    // grant accepted this cycle
   output logic       gnt_valid_o,
   output req_e       gnt_o
);

   req_e r_last;

   // Winner selection: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      gnt_o = CPU;
      if (req_i[0] && req_i[1]) begin
         gnt_o = (r_last == DBG) ? CPU : DBG;
      end else if (req_i[1]) begin
         gnt_o = DBG;
      end
   end

   assign gnt_valid_o = |req_i;

   // Remember the most recent accepted grant; reset favours the CPU on the first tie
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_last <= DBG;
      end else if (update_i && gnt_valid_o) begin
         r_last <= gnt_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Serialises CPU MEM-stage and debug/loader accesses onto a
//             single-port data memory with fixed latency MEM_LAT.
//             Optional DMEM_ARB_PERF_EN adds saturating stall/grant counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,        // asynchronous, active-low
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_done_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              dbg_done_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_stall_o,
   output logic [CNT_W-1:0]  perf_cpu_grant_o,
   output logic [CNT_W-1:0]  perf_dbg_grant_o
`endif
);

   localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(MEM_LAT);
   localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(1);

   generate
      if (!lat_legal(MEM_LAT)) begin : g_lat_check
         $error("dmem_arbiter: MEM_LAT out of range 1..15");
      end
   endgenerate

   state_e             r_state;
   req_e               r_owner;
   logic [c_LAT_W-1:0] r_lat_cnt;
   logic               w_gnt_valid;
   req_e               w_gnt;
   logic               w_issue;

   rr_arb2 u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       ({dbg_req_i, cpu_req_i}),
      .update_i    (w_issue),
      .gnt_valid_o (w_gnt_valid),
      .gnt_o       (w_gnt)
   );

   assign w_issue     = (r_state == IDLE) && w_gnt_valid;
   assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

   // Access sequencer: issue in IDLE, count down latency in BUSY, capture and pulse done
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_owner     <= CPU;
         r_lat_cnt   <= '0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rdata_o <= '0;
         dbg_rdata_o <= '0;
         cpu_done_o  <= 1'b0;
         dbg_done_o  <= 1'b0;
      end else begin
         cpu_done_o <= 1'b0;
         dbg_done_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_owner   <= w_gnt;
                  mem_en_o  <= 1'b1;
                  r_lat_cnt <= c_LAT_LOAD;
                  r_state   <= BUSY;
                  if (w_gnt == DBG) begin
                     mem_we_o    <= dbg_we_i;
                     mem_addr_o  <= dbg_addr_i;
                     mem_wdata_o <= dbg_wdata_i;
                  end else begin
                     mem_we_o    <= cpu_we_i;
                     mem_addr_o  <= cpu_addr_i;
                     mem_wdata_o <= cpu_wdata_i;
                  end
               end
            end
            BUSY: begin
               // Enable is a single-cycle issue strobe; operands stay put
               mem_en_o  <= 1'b0;
               r_lat_cnt <= r_lat_cnt - 1'b1;
               if (r_lat_cnt == c_LAT_LAST) begin
                  r_state <= IDLE;
                  if (r_owner == DBG) begin
                     dbg_done_o <= 1'b1;
                     if (!mem_we_o) dbg_rdata_o <= mem_rdata_i;
                  end else begin
                     cpu_done_o <= 1'b1;
                     if (!mem_we_o) cpu_rdata_o <= mem_rdata_i;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_EN
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [CNT_W-1:0] r_perf_stall;
   logic [CNT_W-1:0] r_perf_cpu;
   logic [CNT_W-1:0] r_perf_dbg;

   // Saturating counters for stall cycles and per-requester grants
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_perf_stall <= '0;
         r_perf_cpu   <= '0;
         r_perf_dbg   <= '0;
      end else begin
         if (cpu_stall_o && (r_perf_stall != c_CNT_MAX))
            r_perf_stall <= r_perf_stall + 1'b1;
         if (w_issue && (w_gnt == CPU) && (r_perf_cpu != c_CNT_MAX))
            r_perf_cpu <= r_perf_cpu + 1'b1;
         if (w_issue && (w_gnt == DBG) && (r_perf_dbg != c_CNT_MAX))
            r_perf_dbg <= r_perf_dbg + 1'b1;
      end
   end

   assign perf_stall_o     = r_perf_stall;
   assign perf_cpu_grant_o = r_perf_cpu;
   assign perf_dbg_grant_o = r_perf_dbg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Self-checking bench for dmem_arbiter (MEM_LAT=2 main instance,
//             MEM_LAT=1 secondary instance) with a fixed-latency memory
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int LAT = 2;
   localparam int CW  = 16;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
   logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0, cpu_rdata_o;
   logic        cpu_done_o, cpu_stall_o;
   logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
   logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0, dbg_rdata_o;
   logic        dbg_done_o;
   logic        mem_en_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef DMEM_ARB_PERF_EN
   logic [CW-1:0] perf_stall_o, perf_cpu_grant_o, perf_dbg_grant_o;
   logic [CW-1:0] l1_perf_stall_o, l1_perf_cpu_grant_o, l1_perf_dbg_grant_o;
`endif

   logic        l1_cpu_req_i = 1'b0;
   logic [31:0] l1_cpu_addr_i = '0, l1_cpu_rdata_o, l1_dbg_rdata_o;
   logic        l1_cpu_done_o, l1_cpu_stall_o, l1_dbg_done_o;
   logic        l1_mem_en_o, l1_mem_we_o;
   logic [31:0] l1_mem_addr_o, l1_mem_wdata_o, l1_mem_rdata_i;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
      .cpu_stall_o(cpu_stall_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_done_o(dbg_done_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_PERF_EN
      , .perf_stall_o(perf_stall_o), .perf_cpu_grant_o(perf_cpu_grant_o),
      .perf_dbg_grant_o(perf_dbg_grant_o)
`endif
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(CW)) dut_l1 (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(l1_cpu_req_i), .cpu_we_i(1'b0), .cpu_addr_i(l1_cpu_addr_i),
      .cpu_wdata_i(32'h0), .cpu_rdata_o(l1_cpu_rdata_o), .cpu_done_o(l1_cpu_done_o),
      .cpu_stall_o(l1_cpu_stall_o),
      .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'h0),
      .dbg_wdata_i(32'h0), .dbg_rdata_o(l1_dbg_rdata_o), .dbg_done_o(l1_dbg_done_o),
      .mem_en_o(l1_mem_en_o), .mem_we_o(l1_mem_we_o), .mem_addr_o(l1_mem_addr_o),
      .mem_wdata_o(l1_mem_wdata_o), .mem_rdata_i(l1_mem_rdata_i)
`ifdef DMEM_ARB_PERF_EN
      , .perf_stall_o(l1_perf_stall_o), .perf_cpu_grant_o(l1_perf_cpu_grant_o),
      .perf_dbg_grant_o(l1_perf_dbg_grant_o)
`endif
   );

   // ---------------- memory environment: valid data only in the capture cycle
   logic [31:0] mem     [0:15];
   logic [31:0] init_v  [0:15];
   logic        preload = 1'b0;
   int          age = 100, l1_age = 100;

   always @(negedge clk_i) begin
      age    = mem_en_o    ? 0 : age + 1;
      l1_age = l1_mem_en_o ? 0 : l1_age + 1;
   end

   always @(posedge clk_i) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_v[i];
      end else if (mem_en_o && mem_we_o) begin
         mem[mem_addr_o[5:2]] <= mem_wdata_o;
      end
   end

   assign mem_rdata_i    = (age == LAT - 1) ? mem[mem_addr_o[5:2]]    : 32'hDEAD_BEEF;
   assign l1_mem_rdata_i = (l1_age == 0)    ? mem[l1_mem_addr_o[5:2]] : 32'hDEAD_BEEF;

   // ---------------- reference model state
   logic [31:0] ref_mem [0:15];
   logic [31:0] ref_cpu_rd, ref_dbg_rd;
   bit          last_dbg;
   int          n_cpu, n_dbg;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      ref_cpu_rd = '0;
      ref_dbg_rd = '0;
      last_dbg   = 1'b1;
      n_cpu      = 0;
      n_dbg      = 0;
   endtask

   task automatic rand_ops(input bit for_dbg);
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      if (for_dbg) begin
         dbg_we_i = 1'($urandom_range(0, 1)); dbg_addr_i = {26'b0, w, 2'b00}; dbg_wdata_i = $urandom;
      end else begin
         cpu_we_i = 1'($urandom_range(0, 1)); cpu_addr_i = {26'b0, w, 2'b00}; cpu_wdata_i = $urandom;
      end
   endtask

   // Follow one access of the predicted winner from grant to done
   task automatic serve(input bit who_dbg, input bit keep, input bit drop_early);
      int          c;
      bit          seen;
      logic        we;
      logic [31:0] addr, wd;
      we   = who_dbg ? dbg_we_i    : cpu_we_i;
      addr = who_dbg ? dbg_addr_i  : cpu_addr_i;
      wd   = who_dbg ? dbg_wdata_i : cpu_wdata_i;
      c = 0;
      seen = 1'b0;
      while (!seen && c < 20) begin
         tick();
         c++;
         if (c == 1) begin
            chk("issue_en",    32'(mem_en_o), 32'd1);
            chk("issue_we",    32'(mem_we_o), 32'(we));
            chk("issue_addr",  mem_addr_o, addr);
            chk("issue_wdata", mem_wdata_o, wd);
            chk("busy_stall",  32'(cpu_stall_o), 32'(cpu_req_i));
            if (who_dbg) n_dbg++; else n_cpu++;
            last_dbg = who_dbg;
            if (drop_early) begin
               if (who_dbg) dbg_req_i = 1'b0; else cpu_req_i = 1'b0;
            end
         end
         if (c == 2 && LAT >= 2) chk("en_one_cycle", 32'(mem_en_o), 32'd0);
         seen = who_dbg ? dbg_done_o : cpu_done_o;
      end
      chk(who_dbg ? "dbg_latency" : "cpu_latency", 32'(c), 32'(LAT + 1));
      chk("other_done", 32'(who_dbg ? cpu_done_o : dbg_done_o), 32'd0);
      if (we) ref_mem[addr[5:2]] = wd;
      else if (who_dbg) ref_dbg_rd = ref_mem[addr[5:2]];
      else ref_cpu_rd = ref_mem[addr[5:2]];
      chk("cpu_rdata", cpu_rdata_o, ref_cpu_rd);
      chk("dbg_rdata", dbg_rdata_o, ref_dbg_rd);
      chk("done_stall", 32'(cpu_stall_o), 32'(who_dbg && cpu_req_i));
      if (keep) rand_ops(who_dbg);
      else if (who_dbg) dbg_req_i = 1'b0;
      else cpu_req_i = 1'b0;
   endtask

   // Raise the chosen requests together and follow them in predicted order
   task automatic pair(input bit cr, input bit dr);
      bit first_dbg;
      cpu_req_i = cr;
      dbg_req_i = dr;
      first_dbg = (cr && dr) ? !last_dbg : dr;
      serve(first_dbg, 1'b0, 1'b0);
      if (cr && dr) serve(!first_dbg, 1'b0, 1'b0);
   endtask

   initial begin
      int  c;
      bit  cr, dr;
      for (int i = 0; i < 16; i++) begin
         init_v[i]  = $urandom;
         ref_mem[i] = init_v[i];
      end
      init_v[0] = 32'd5; ref_mem[0] = 32'd5;
      model_reset();

      // Reset values
      #2 rst_i = 1'b0;
      preload = 1'b1;
      tick(); tick();
      preload = 1'b0;
      chk("rst_mem_en",  32'(mem_en_o), 32'd0);
      chk("rst_mem_we",  32'(mem_we_o), 32'd0);
      chk("rst_addr",    mem_addr_o, 32'd0);
      chk("rst_wdata",   mem_wdata_o, 32'd0);
      chk("rst_cpu_done", 32'(cpu_done_o), 32'd0);
      chk("rst_dbg_done", 32'(dbg_done_o), 32'd0);
      chk("rst_cpu_rd",  cpu_rdata_o, 32'd0);
      chk("rst_dbg_rd",  dbg_rdata_o, 32'd0);
      chk("rst_l1_en",   32'(l1_mem_en_o), 32'd0);
      rst_i = 1'b1;
      tick();

      // Single CPU read of address 0 returning 5
      cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h1234;
      pair(1'b1, 1'b0);
      chk("read5", cpu_rdata_o, 32'd5);

      // Reset in the middle of an access
      cpu_we_i = 1'b0; cpu_addr_i = 32'h8; cpu_req_i = 1'b1;
      tick();
      chk("pre_rst_en", 32'(mem_en_o), 32'd1);
      rst_i = 1'b0;
      #1;
      chk("mid_rst_en",   32'(mem_en_o), 32'd0);
      chk("mid_rst_addr", mem_addr_o, 32'd0);
      chk("mid_rst_rd",   cpu_rdata_o, 32'd0);
      cpu_req_i = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_rst_done", 32'(cpu_done_o), 32'd0);
      end
      rst_i = 1'b1;
      tick();
      chk("post_rst_done", 32'(cpu_done_o), 32'd0);

      // Tie straight after reset: CPU first, DBG one full access later
      cpu_we_i = 1'b0; cpu_addr_i = 32'hC;
      dbg_we_i = 1'b0; dbg_addr_i = 32'h1C;
      chk("tie_model_cpu_first", 32'(last_dbg), 32'd1);
      pair(1'b1, 1'b1);

      // Debug write 0x2A to 0x04 then CPU read it back
      dbg_we_i = 1'b1; dbg_addr_i = 32'h4; dbg_wdata_i = 32'h2A;
      pair(1'b0, 1'b1);
      cpu_we_i = 1'b0; cpu_addr_i = 32'h4;
      pair(1'b1, 1'b0);
      chk("dbg_wr_cpu_rd", cpu_rdata_o, 32'h2A);

      // Continuous contention: ten strictly alternating grants
      rand_ops(1'b0);
      rand_ops(1'b1);
      cpu_req_i = 1'b1;
      dbg_req_i = 1'b1;
      for (int i = 0; i < 10; i++) serve(!last_dbg, (i < 8), 1'b0);
`ifdef DMEM_ARB_PERF_EN
      chk("perf_cpu", 32'(perf_cpu_grant_o), 32'(n_cpu));
      chk("perf_dbg", 32'(perf_dbg_grant_o), 32'(n_dbg));
`endif

      // Request withdrawn mid-access still completes
      rand_ops(1'b0);
      cpu_req_i = 1'b1;
      serve(1'b0, 1'b0, 1'b1);

      // Random traffic
      for (int r = 0; r < 12; r++) begin
         cr = 1'($urandom_range(0, 1));
         dr = cr ? 1'($urandom_range(0, 1)) : 1'b1;
         rand_ops(1'b0);
         rand_ops(1'b1);
         pair(cr, dr);
      end

      // MEM_LAT=1 instance: done two edges after the request is raised
      l1_cpu_addr_i = 32'h8;
      l1_cpu_req_i  = 1'b1;
      c = 0;
      while (!l1_cpu_done_o && c < 20) begin
         tick();
         c++;
         if (c == 1) begin
            chk("l1_issue_en", 32'(l1_mem_en_o), 32'd1);
            l1_cpu_req_i = 1'b0;
         end
      end
      chk("l1_latency", 32'(c), 32'd2);
      chk("l1_rdata", l1_cpu_rdata_o, ref_mem[2]);

      tick();
      chk("final_cpu_done", 32'(cpu_done_o), 32'd0);
      chk("final_dbg_done", 32'(dbg_done_o), 32'd0);
      chk("final_l1_done",  32'(l1_cpu_done_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
